// File: rtl/ram_scan_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ram_scan_ctrl_pkg                                          |
// | Purpose : Shared types and defaults for the RAM scan controller:     |
// |           FSM state encoding, default RAM widths, counter sizing.    |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package ram_scan_ctrl_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  // Bits needed for a counter running 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_scan_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ram_scan_ctrl_if                                           |
// | Purpose : Single-port RAM bus between the scan controller and RAM.   |
// | Ports   : ram_address/ram_data/ram_wren (controller -> RAM),         |
// |           ram_q (RAM -> controller); modports master / slave.        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface ram_scan_ctrl_if
  import ram_scan_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport master (output ram_address, output ram_data, output ram_wren, input ram_q);
  modport slave  (input ram_address, input ram_data, input ram_wren, output ram_q);
endinterface
`default_nettype wire

// File: rtl/ram_scan_ctrl_key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ram_scan_ctrl_key_debounce                                 |
// | Purpose : Synchronise a raw active-low pushbutton, accept a new      |
// |           level only after DEBOUNCE_CYC stable cycles, and emit a    |
// |           one-cycle pulse when the accepted level falls (press).     |
// | Ports   : clk, rst_n (async active-low), key_n (raw, async),         |
// |           fall (1-cycle press pulse)                                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ram_scan_ctrl_key_debounce
  import ram_scan_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic fall
);

  localparam int               CNT_W     = cnt_w(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  // Counter runs only while the synchronised input differs from the
  // accepted level; any agreement (a bounce back) restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_fall   <= 1'b0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_fall  <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_MAX) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
        r_fall   <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/ram_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ram_scan_ctrl                                              |
// | Purpose : Owns a single-port RAM; steps a display read address once  |
// |           per tick and captures the word read, and commits one       |
// |           switch-selected write per debounced key press.             |
// | Ports   : CLOCK_50, resetn (async active-low), wr_key_n (raw key),   |
// |           wr_addr/wr_data (switches), ram (RAM bus master),          |
// |           rd_addr/rd_data (word shown), rd_valid (update pulse)      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ram_scan_ctrl
  import ram_scan_ctrl_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_HZ      = 1,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RD_LAT       = 1,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  wr_key_n,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  ram_scan_ctrl_if.master       ram,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid
);

  localparam int               DIV       = CLK_HZ / TICK_HZ;
  localparam int               PRE_W     = cnt_w(DIV);
  localparam logic [PRE_W-1:0] C_PRE_MAX = PRE_W'(DIV - 1);
  localparam int               LAT_W     = 2;
  localparam logic [LAT_W-1:0] C_LAT_MAX = LAT_W'(RD_LAT - 1);

  logic [PRE_W-1:0]  r_presc;
  logic [ADDR_W-1:0] r_scan_addr;
  logic [ADDR_W-1:0] r_ra;
  logic [ADDR_W-1:0] r_wa;
  logic [DATA_W-1:0] r_wd;
  logic [LAT_W-1:0]  r_lat;
  logic              r_refresh_pend;
  logic              r_write_pend;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  state_t            r_state;
  state_t            w_next;
  logic              w_tick;
  logic              w_key_fall;
  logic              w_rd_done;

  ram_scan_ctrl_key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_key (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .key_n (wr_key_n),
    .fall  (w_key_fall)
  );

  assign w_tick    = (r_presc == C_PRE_MAX);
  assign w_rd_done = (r_state == ST_READ) && (r_lat == C_LAT_MAX);

  // Prescaler and scan address; the address wraps naturally at 2**ADDR_W.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_presc     <= '0;
      r_scan_addr <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
      if (w_tick) r_scan_addr <= r_scan_addr + ADDR_W'(1);
    end
  end

  // Request flags. refresh_pend comes out of reset set so the display is
  // loaded from address 0 straight away. A re-set from a tick or a write
  // wins over the clear at read completion so no refresh is lost. A press
  // arriving while a write is still pending is simply dropped.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_refresh_pend <= 1'b1;
      r_write_pend   <= 1'b0;
      r_wa           <= '0;
      r_wd           <= '0;
    end else begin
      if (w_tick || (r_state == ST_WRITE)) r_refresh_pend <= 1'b1;
      else if (w_rd_done)                  r_refresh_pend <= 1'b0;

      if (r_state == ST_WRITE) begin
        r_write_pend <= 1'b0;
      end else if (w_key_fall && !r_write_pend) begin
        r_write_pend <= 1'b1;
        r_wa         <= wr_addr;
        r_wd         <= wr_data;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // FSM next state; a pending write always goes ahead of a refresh.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (r_write_pend)        w_next = ST_WRITE;
        else if (r_refresh_pend) w_next = ST_READ;
      end
      ST_WRITE: w_next = ST_IDLE;
      ST_READ:  if (w_rd_done) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // FSM outputs. In IDLE the scan address is already on the bus, so the
  // RAM starts the read on the same edge that enters READ; ra captures that
  // address so a tick during READ cannot disturb the read in flight.
  always_comb begin
    ram.ram_address = r_scan_addr;
    ram.ram_wren    = 1'b0;
    case (r_state)
      ST_WRITE: begin
        ram.ram_address = r_wa;
        ram.ram_wren    = 1'b1;
      end
      ST_READ: ram.ram_address = r_ra;
      default: ;
    endcase
  end

  assign ram.ram_data = r_wd;

  // Read datapath: latency counter and the displayed word.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_ra       <= '0;
      r_lat      <= '0;
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_done;
      if ((r_state == ST_IDLE) && (w_next == ST_READ)) r_ra <= r_scan_addr;
      r_lat <= (r_state == ST_READ) ? r_lat + LAT_W'(1) : '0;
      if (w_rd_done) begin
        r_rd_addr <= r_ra;
        r_rd_data <= ram.ram_q;
      end
    end
  end

  assign rd_addr  = r_rd_addr;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_ram_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ram_scan_ctrl                                           |
// | Purpose : Self-checking bench for ram_scan_ctrl with a behavioural   |
// |           32x4 RAM and a reference memory image.                     |
// | Ports   : none                                                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_ram_scan_ctrl;

  localparam int AW  = 5;
  localparam int DW  = 4;
  localparam int PER = 8;   // CLK_HZ / TICK_HZ cycles per scan step

  logic          clk     = 1'b0;
  logic          resetn  = 1'b0;
  logic          key_n   = 1'b1;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  ram_scan_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ram_bus ();

  ram_scan_ctrl #(
    .CLK_HZ(8), .TICK_HZ(1), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .DEBOUNCE_CYC(4)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .wr_key_n (key_n),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ram      (ram_bus),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, one cycle read latency.
  logic [DW-1:0] mem [32];
  logic          load = 1'b1;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= DW'(i);
    end else if (ram_bus.ram_wren) begin
      mem[ram_bus.ram_address] <= ram_bus.ram_data;
    end
    ram_bus.ram_q <= mem[ram_bus.ram_address];
  end

  // Cycles since reset release: edge n after release gives cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= resetn ? cyc + 1 : 0;

  int wren_cnt = 0;
  always @(negedge clk) if (ram_bus.ram_wren) wren_cnt <= wren_cnt + 1;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] ref_mem [32];
  bit            busy = 1'b0;
  logic [AW-1:0] busy_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every displayed word: its address is the scan position (tick count)
  // as it stood two cycles before rd_valid, and its data is the reference
  // image unless a write to that word is still in progress.
  task automatic mon();
    logic [AW-1:0] exp_a;
    if (resetn && rd_valid) begin
      exp_a = AW'(((cyc - 2) / PER) % 32);
      chk("scan_rd_addr", 32'(rd_addr), 32'(exp_a));
      if (!(busy && rd_addr == busy_addr))
        chk("scan_rd_data", 32'(rd_data), 32'(ref_mem[rd_addr]));
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
  endtask

  task automatic wait_rv(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      step();
      if (rd_valid) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [15:0]   pat;   // bit i set: key held low in cycle i
    int            len;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            nwr;   // writes the pattern must produce
  } kvec_t;

  kvec_t tbl [6];

  initial begin
    bit            ok;
    int            last;
    int            w0;
    int            errs;
    int            k;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    tbl[0] = '{16'h003F, 6, 5'd7,  4'hA, 1};  // clean press
    tbl[1] = '{16'h001B, 5, 5'd3,  4'h9, 0};  // low 2, high 1, low 2
    tbl[2] = '{16'h001F, 5, 5'd3,  4'h9, 1};  // held low 5
    tbl[3] = '{16'h0007, 3, 5'd12, 4'h6, 0};  // one short of debounce
    tbl[4] = '{16'h000F, 4, 5'd12, 4'h6, 1};  // exactly debounce length
    tbl[5] = '{16'h00FF, 8, 5'd20, 4'h1, 1};
    for (int i = 0; i < 32; i++) ref_mem[i] = DW'(i);

    // Reset state
    repeat (3) @(negedge clk);
    load = 1'b0;
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_wren", 32'(ram_bus.ram_wren), 0);

    // First read of address 0, two cycles after release
    resetn = 1'b1;
    step();
    chk("t1_no_valid_c1", 32'(rd_valid), 0);
    step();
    chk("t1_valid_c2", 32'(rd_valid), 1);
    chk("t1_rd_addr", 32'(rd_addr), 0);
    chk("t1_rd_data", 32'(rd_data), 0);

    // 40 ticks: one read per tick, in order, PER cycles apart
    last = cyc;
    for (int j = 1; j <= 40; j++) begin
      wait_rv(12, ok);
      chk("t2_read_seen", 32'(ok), 1);
      chk("t2_rd_addr", 32'(rd_addr), 32'(j % 32));
      chk("t2_spacing", 32'(cyc - last), PER);
      last = cyc;
    end

    // Key pattern table
    for (int t = 0; t < 6; t++) begin
      w0 = wren_cnt;
      wr_addr = tbl[t].a; wr_data = tbl[t].d;
      busy = 1'b1; busy_addr = tbl[t].a;
      for (int i = 0; i < tbl[t].len; i++) begin
        key_n = ~tbl[t].pat[i];
        step();
      end
      key_n = 1'b1;
      repeat (16) step();
      chk("tbl_wren_count", 32'(wren_cnt - w0), 32'(tbl[t].nwr));
      if (tbl[t].nwr != 0) ref_mem[tbl[t].a] = tbl[t].d;
      chk("tbl_mem_word", 32'(mem[tbl[t].a]), 32'(ref_mem[tbl[t].a]));
      busy = 1'b0;
    end

    // Written word shows up when the scan reaches address 7
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      step();
      if (rd_valid && rd_addr == 5'd7) ok = 1'b1;
    end
    chk("t3_addr7_seen", 32'(ok), 1);
    chk("t3_addr7_data", 32'(rd_data), 32'hA);

    // Press accepted in the same cycle as a tick, aimed at the next scan
    // address: the write must land before the read it collides with.
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      step();
      if (cyc % PER == 1 && ref_mem[(cyc / PER + 1) % 32] != 4'd5) ok = 1'b1;
    end
    chk("t5_aligned", 32'(ok), 1);
    k = cyc / PER;
    a = AW'((k + 1) % 32);
    w0 = wren_cnt;
    wr_addr = a; wr_data = 4'd5; busy = 1'b1; busy_addr = a;
    key_n = 1'b0;
    repeat (6) step();
    key_n = 1'b1;
    wait_rv(12, ok);
    chk("t5_read_seen", 32'(ok), 1);
    chk("t5_wrote_first", 32'(wren_cnt - w0), 1);
    chk("t5_rd_addr", 32'(rd_addr), 32'(a));
    chk("t5_rd_data", 32'(rd_data), 5);
    repeat (12) step();
    ref_mem[a] = 4'd5;
    busy = 1'b0;

    // Reset during WRITE: wren drops at once, the word is left alone
    wr_addr = 5'd9; wr_data = ~ref_mem[9]; busy = 1'b1; busy_addr = 5'd9;
    key_n = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (ram_bus.ram_wren) ok = 1'b1;
    end
    chk("t6_write_started", 32'(ok), 1);
    #1 resetn = 1'b0;
    key_n = 1'b1;
    #1 chk("t6_wren_async_drop", 32'(ram_bus.ram_wren), 0);
    step();
    step();
    chk("t6_mem_kept", 32'(mem[9]), 32'(ref_mem[9]));
    chk("t6_rst_rd_addr", 32'(rd_addr), 0);
    resetn = 1'b1;
    step();
    step();
    chk("t6_valid_c2", 32'(rd_valid), 1);
    chk("t6_rd_addr", 32'(rd_addr), 0);
    chk("t6_rd_data", 32'(rd_data), 32'(ref_mem[0]));
    busy = 1'b0;

    // Random presses against the reference image
    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(2, 20)) step();
      a = AW'($urandom_range(0, 31));
      d = DW'($urandom_range(0, 15));
      w0 = wren_cnt;
      wr_addr = a; wr_data = d; busy = 1'b1; busy_addr = a;
      key_n = 1'b0;
      repeat ($urandom_range(4, 9)) step();
      key_n = 1'b1;
      repeat (12) step();
      chk("rnd_wren_count", 32'(wren_cnt - w0), 1);
      ref_mem[a] = d;
      busy = 1'b0;
    end
    repeat (300) step();  // a full scan so every word is shown again
    errs = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) errs++;
    chk("rnd_mem_image", 32'(errs), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
